sd_resp_tx: RTL and testbench



---
 rtl/sd_pkg.sv | 20 ++
 rtl/sd_crc7.sv | 40 ++++
 rtl/sd_resp_tx.sv | 174 +++++++++++++++++
 tb/tb_sd_resp_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SD/SDIO definitions: response transmitter states, frame geometry
// and the CRC7 generator polynomial.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        CRC,
        END
    } resp_tx_state_t;

    localparam int SD_CMD_FRAME_BITS = 48;
    localparam int SD_CMD_CRC_BITS   = 40;
    localparam int SD_CRC7_WIDTH     = 7;

    // x^7 + x^3 + 1, with the x^7 term implied by the shift-out
    localparam logic [SD_CRC7_WIDTH-1:0] SD_CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 engine (x^7+x^3+1, initial value 0). It takes one bit per
// enabled clock. Clear has priority over enable.
module sd_crc7
    import sd_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     in_bit,
    output logic [SD_CRC7_WIDTH-1:0] crc
);

    logic [SD_CRC7_WIDTH-1:0] crc_q;
    logic [SD_CRC7_WIDTH-1:0] crc_d;
    logic                     feedback;

    // Next CRC value: shift in one message bit, folding in the polynomial
    always_comb begin
        crc_d    = crc_q;
        feedback = in_bit ^ crc_q[SD_CRC7_WIDTH-1];
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = {crc_q[SD_CRC7_WIDTH-2:0], 1'b0} ^ (feedback ? SD_CRC7_POLY : '0);
        end
    end

    // CRC state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_resp_tx.sv
// Card-side R1 response transmitter for the SD CMD line.
//
// state | meaning
// IDLE  | line released, waiting for start
// WAIT  | N_CR turnaround, line still released
// DATA  | start/dir/index/argument bits on the line (40)
// CRC   | CRC7 bits on the line, crc[6] first (7)
// END   | end bit (1) on the line
//
// The state names the bit currently on the line. Outputs are registered, so
// each bit is loaded on the edge that enters its cycle. The CRC engine
// absorbs each data bit on the edge that puts it on the line. This leaves the
// full CRC ready in time to load crc[6] as the last data bit leaves.
module sd_resp_tx
    import sd_pkg::*;
#(
    parameter int NCR_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        cmd_out,
    output logic        cmd_oe
);

    localparam logic [5:0] WAIT_LOAD = 6'(NCR_CYCLES - 1);
    localparam logic [5:0] DATA_LAST = 6'(SD_CMD_CRC_BITS - 1);
    localparam logic [5:0] CRC_LAST  = 6'(SD_CRC7_WIDTH - 1);

    resp_tx_state_t                 state_q, state_d;
    logic [SD_CMD_CRC_BITS-1:0]     shift_q, shift_d;
    logic [SD_CRC7_WIDTH-1:0]       crc_shift_q, crc_shift_d;
    logic [5:0]                     bit_cnt_q, bit_cnt_d;
    logic [5:0]                     wait_cnt_q, wait_cnt_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           cmd_out_q, cmd_out_d;
    logic                           cmd_oe_q, cmd_oe_d;

    logic                           crc_clear;
    logic                           crc_enable;
    logic [SD_CRC7_WIDTH-1:0]       crc_value;

    sd_crc7 u_crc7 (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (crc_clear),
        .enable  (crc_enable),
        .in_bit  (shift_q[SD_CMD_CRC_BITS-1]),
        .crc     (crc_value)
    );

    // Next-state and next-output decode; abort overrides any active frame
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        crc_shift_d = crc_shift_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cmd_out_d   = cmd_out_q;
        cmd_oe_d    = cmd_oe_q;
        crc_clear   = 1'b0;
        crc_enable  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT;
                    shift_d    = {2'b00, cmd_index, argument};
                    wait_cnt_d = WAIT_LOAD;
                    busy_d     = 1'b1;
                    crc_clear  = 1'b1;
                    cmd_oe_d   = 1'b0;
                    cmd_out_d  = 1'b1;
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d    = DATA;
                    bit_cnt_d  = '0;
                    cmd_oe_d   = 1'b1;
                    cmd_out_d  = shift_q[SD_CMD_CRC_BITS-1];
                    shift_d    = {shift_q[SD_CMD_CRC_BITS-2:0], 1'b0};
                    crc_enable = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 6'd1;
                end
            end
            DATA: begin
                if (bit_cnt_q == DATA_LAST) begin
                    state_d     = CRC;
                    bit_cnt_d   = '0;
                    cmd_out_d   = crc_value[SD_CRC7_WIDTH-1];
                    crc_shift_d = {crc_value[SD_CRC7_WIDTH-2:0], 1'b0};
                end else begin
                    bit_cnt_d  = bit_cnt_q + 6'd1;
                    cmd_out_d  = shift_q[SD_CMD_CRC_BITS-1];
                    shift_d    = {shift_q[SD_CMD_CRC_BITS-2:0], 1'b0};
                    crc_enable = 1'b1;
                end
            end
            CRC: begin
                if (bit_cnt_q == CRC_LAST) begin
                    state_d   = END;
                    cmd_out_d = 1'b1;
                end else begin
                    bit_cnt_d   = bit_cnt_q + 6'd1;
                    cmd_out_d   = crc_shift_q[SD_CRC7_WIDTH-1];
                    crc_shift_d = {crc_shift_q[SD_CRC7_WIDTH-2:0], 1'b0};
                end
            end
            END: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                cmd_oe_d  = 1'b0;
                cmd_out_d = 1'b1;
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                cmd_oe_d  = 1'b0;
                cmd_out_d = 1'b1;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            cmd_oe_d   = 1'b0;
            cmd_out_d  = 1'b1;
            crc_enable = 1'b0;
        end
    end

    // FSM, datapath and registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            crc_shift_q <= '0;
            bit_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_out_q   <= 1'b1;
            cmd_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            crc_shift_q <= crc_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_out_q   <= cmd_out_d;
            cmd_oe_q    <= cmd_oe_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cmd_out = cmd_out_q;
    assign cmd_oe  = cmd_oe_q;

endmodule

// File: tb/tb_sd_resp_tx.sv
// Bench for sd_resp_tx. Two builds run side by side: NCR_CYCLES=2 and
// NCR_CYCLES=8. A cycle-offset model predicts busy/done/cmd_oe/cmd_out
// from the frame timing rules.
module tb_sd_resp_tx;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        abort;
    logic [1:0]  start;
    logic [5:0]  cmd_index;
    logic [31:0] argument;
    logic [1:0]  busy, done, cmd_out, cmd_oe;

    int errors = 0;
    int checks = 0;
    int shown  = 0;

    always #5 clock = ~clock;

    sd_resp_tx #(.NCR_CYCLES(2)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start[0]),
        .cmd_index(cmd_index), .argument(argument), .abort(abort),
        .busy(busy[0]), .done(done[0]), .cmd_out(cmd_out[0]), .cmd_oe(cmd_oe[0])
    );

    sd_resp_tx #(.NCR_CYCLES(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start[1]),
        .cmd_index(cmd_index), .argument(argument), .abort(abort),
        .busy(busy[1]), .done(done[1]), .cmd_out(cmd_out[1]), .cmd_oe(cmd_oe[1])
    );

    // CRC7 from its definition: polynomial division of the 40 message bits
    function automatic logic [6:0] crc7_of(input logic [39:0] msg);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = msg[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] msg;
        msg = {2'b00, idx, arg};
        return {msg, crc7_of(msg), 1'b1};
    endfunction

    // Model: cycles elapsed since acceptance (0 = idle) and the expected frame
    int          ncr [2] = '{2, 8};
    int          age [2] = '{0, 0};
    bit          mdone [2] = '{0, 0};
    logic [47:0] mframe [2];

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                age[d]   = 0;
                mdone[d] = 0;
            end else if (age[d] == 0) begin
                mdone[d] = 0;
                if (start[d]) begin
                    age[d]    = 1;
                    mframe[d] = frame_of(cmd_index, argument);
                end
            end else if (abort) begin
                age[d]   = 0;
                mdone[d] = 0;
            end else begin
                age[d] = age[d] + 1;
                if (age[d] == ncr[d] + 49) begin
                    age[d]   = 0;
                    mdone[d] = 1;
                end
            end
        end
    end

    function automatic logic [3:0] expected(input int d);
        if (age[d] == 0)           return {1'b0, mdone[d], 1'b0, 1'b1};
        else if (age[d] <= ncr[d]) return 4'b1001;
        else                       return {1'b1, 1'b0, 1'b1, mframe[d][47 - (age[d] - ncr[d] - 1)]};
    endfunction

    bit check_en = 0;

    // Per-cycle comparison of {busy, done, cmd_oe, cmd_out} against the model
    always @(negedge clock) begin
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [3:0] act, exp_v;
                act   = {busy[d], done[d], cmd_oe[d], cmd_out[d]};
                exp_v = expected(d);
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    if (shown < 30) begin
                        shown++;
                        $display("FAIL cycle_ncr%0d t=%0t {busy,done,oe,out} got %b expected %b",
                                 ncr[d], $time, act, exp_v);
                    end
                end
            end
        end
    end

    // Last 48 driven bits and running count of driven cycles, per build
    logic [47:0] cap [2];
    int          oe_cnt [2] = '{0, 0};

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (cmd_oe[d] === 1'b1) begin
                cap[d]    = {cap[d][46:0], cmd_out[d]};
                oe_cnt[d] = oe_cnt[d] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic wait_done(input int d, output int n);
        n = 0;
        while (done[d] !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (done[d] !== 1'b1) chk("done_timeout", 64'(done[d]), 64'd1);
    endtask

    task automatic wait_oe(input int d, output int n);
        n = 0;
        while (cmd_oe[d] !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (cmd_oe[d] !== 1'b1) chk("oe_timeout", 64'(cmd_oe[d]), 64'd1);
    endtask

    // Issue one request from idle and return cycles from acceptance to done
    task automatic run_frame(input int d, input logic [5:0] idx, input logic [31:0] arg,
                             output int lat);
        int n0, n;
        n0        = oe_cnt[d];
        cmd_index = idx;
        argument  = arg;
        start[d]  = 1'b1;
        @(negedge clock);
        start[d]  = 1'b0;
        wait_done(d, n);
        lat = n + 1;
        chk("frame_bits", cap[d], frame_of(idx, arg));
        chk("oe_cycles", 64'(oe_cnt[d] - n0), 64'd48);
    endtask

    initial begin
        int          lat, n;
        logic [5:0]  i1;
        logic [31:0] a1;

        reset_n   = 1'b0;
        start     = '0;
        abort     = 1'b0;
        cmd_index = '0;
        argument  = '0;
        repeat (3) @(negedge clock);
        check_en = 1;
        chk("reset_state", 64'({busy[0], done[0], cmd_oe[0], cmd_out[0]}), 64'b0001);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        chk("idle_state", 64'({busy[1], done[1], cmd_oe[1], cmd_out[1]}), 64'b0001);

        // Pin the model's CRC and framing against hand-derived values
        chk("model_crc", 64'(crc7_of(40'h11_0000_0900)), 64'h33);
        chk("model_frame", 64'(frame_of(6'h11, 32'h0000_0900)), 64'h1100_0009_0067);
        chk("model_zero", 64'(frame_of(6'h00, 32'h0)), 64'h1);

        run_frame(0, 6'h11, 32'h0000_0900, lat);
        chk("lat_ncr2", 64'(lat), 64'd51);
        chk("frame_cmd17", cap[0], 64'h1100_0009_0067);

        run_frame(0, 6'h00, 32'h0, lat);
        chk("frame_zero", cap[0], 64'h1);

        // Mid-frame start ignored, start in the done cycle accepted
        i1 = 6'h2a;
        a1 = $urandom;
        cmd_index = i1;
        argument  = a1;
        start[0]  = 1'b1;
        @(negedge clock);
        start[0]  = 1'b0;
        repeat (20) @(negedge clock);
        cmd_index = 6'h15;
        argument  = ~a1;
        start[0]  = 1'b1;
        @(negedge clock);
        start[0]  = 1'b0;
        wait_done(0, n);
        chk("first_frame_kept", cap[0], frame_of(i1, a1));
        cmd_index = 6'h3f;
        argument  = 32'hdead_beef;
        start[0]  = 1'b1;
        @(negedge clock);
        start[0]  = 1'b0;
        n = 1;
        while (cmd_oe[0] !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("b2b_gap", 64'(n), 64'd3);
        wait_done(0, n);
        chk("b2b_frame", cap[0], frame_of(6'h3f, 32'hdead_beef));
        repeat (3) @(negedge clock);

        // Abort while data bit 20 is on the line
        cmd_index = 6'h07;
        argument  = $urandom;
        start[0]  = 1'b1;
        @(negedge clock);
        start[0]  = 1'b0;
        wait_oe(0, n);
        repeat (20) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_release", 64'({busy[0], cmd_oe[0], cmd_out[0]}), 64'b001);
        repeat (4) @(negedge clock);
        run_frame(0, 6'(($urandom)), $urandom, lat);
        chk("lat_after_abort", 64'(lat), 64'd51);

        // Reset while CRC bit 2 is on the line
        cmd_index = 6'h33;
        argument  = $urandom;
        start[0]  = 1'b1;
        @(negedge clock);
        start[0]  = 1'b0;
        wait_oe(0, n);
        repeat (42) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("reset_release", 64'({busy[0], done[0], cmd_oe[0], cmd_out[0]}), 64'b0001);
        run_frame(0, 6'(($urandom)), $urandom, lat);

        // Longer turnaround build
        for (int r = 0; r < 3; r++) begin
            run_frame(1, 6'(($urandom)), $urandom, lat);
            chk("lat_ncr8", 64'(lat), 64'd57);
        end

        // Randomised traffic on both builds
        for (int c = 0; c < 3000; c++) begin
            start[0]  = ($urandom_range(0, 15) == 0);
            start[1]  = ($urandom_range(0, 15) == 0);
            cmd_index = 6'(($urandom));
            argument  = $urandom;
            abort     = ($urandom_range(0, 299) == 0);
            reset_n   = ($urandom_range(0, 999) != 0);
            @(negedge clock);
        end
        start   = '0;
        abort   = 1'b0;
        reset_n = 1'b1;
        repeat (70) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
